btn_conditioner: RTL and testbench

BTN_CONDITIONER -- requirements
Module: btn_conditioner

---
 rtl/btn_conditioner.sv | 168 ++++++++++++++++
 tb/tb_btn_conditioner.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/btn_conditioner.sv
// Keypad front end: synchronizes, debounces and edge-detects seven board inputs,
// and adds press-and-hold auto-repeat on the four direction keys.
module btn_conditioner #(
  parameter int DEB_CYCLES = 270000,
  parameter int REP_DELAY  = 13500000,
  parameter int REP_PERIOD = 2700000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_raw,
  input  logic       a_raw,
  input  logic       b_raw,
  input  logic       mode_raw,
  output logic [3:0] dir_pulse,
  output logic       a_pulse,
  output logic       b_pulse,
  output logic       a_held,
  output logic       b_held,
  output logic       mode
);

  localparam int CW   = $clog2(DEB_CYCLES + 1);
  localparam int TMAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [CW-1:0] DEB_LAST    = CW'(DEB_CYCLES - 1);
  localparam logic [TW-1:0] DELAY_LAST  = TW'(REP_DELAY - 1);
  localparam logic [TW-1:0] PERIOD_LAST = TW'(REP_PERIOD - 1);

  // Raw level of each input when nothing is pressed (keys active-low, mode switch active-high)
  localparam logic [6:0] REST_LVL = 7'b0111111;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DELAY  = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  logic [6:0]    raw_all;
  logic [6:0]    sync1;
  logic [6:0]    sync2;
  logic [6:0]    act;
  logic [6:0]    deb;
  logic [6:0]    deb_next;
  logic [6:0]    flip;
  logic [5:0]    press;
  logic [CW-1:0] cnt [7];

  logic [1:0]    state;
  logic [1:0]    state_n;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_n;
  logic [1:0]    track;
  logic [1:0]    track_n;
  logic [1:0]    key_idx;
  logic          one_key;
  logic          same_key;
  logic [3:0]    rep;

  assign raw_all = {mode_raw, b_raw, a_raw, btn_raw};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= REST_LVL;
      sync2 <= REST_LVL;
    end else begin
      sync1 <= raw_all;
      sync2 <= sync1;
    end
  end

  assign act = sync2 ^ REST_LVL;

  always_comb begin
    flip = '0;
    for (int i = 0; i < 7; i++) begin
      flip[i] = (act[i] != deb[i]) && (cnt[i] == DEB_LAST);
    end
    deb_next = deb ^ flip;
    press    = flip[5:0] & ~deb[5:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      deb <= '0;
      for (int i = 0; i < 7; i++) cnt[i] <= '0;
    end else begin
      deb <= deb_next;
      for (int i = 0; i < 7; i++) begin
        if ((act[i] == deb[i]) || flip[i]) cnt[i] <= '0;
        else                               cnt[i] <= cnt[i] + CW'(1);
      end
    end
  end

  // Repeat decisions look at the debounced level being committed this edge,
  // so the hold delay is measured from the press pulse itself.
  always_comb begin
    one_key = (deb_next[3:0] != 4'd0) &&
              ((deb_next[3:0] & (deb_next[3:0] - 4'd1)) == 4'd0);
    case (deb_next[3:0])
      4'b0010: key_idx = 2'd1;
      4'b0100: key_idx = 2'd2;
      4'b1000: key_idx = 2'd3;
      default: key_idx = 2'd0;
    endcase
    same_key = one_key && (key_idx == track);
  end

  always_comb begin
    state_n = state;
    timer_n = timer;
    track_n = track;
    rep     = 4'd0;
    case (state)
      ST_IDLE: begin
        if (one_key) begin
          state_n = ST_DELAY;
          timer_n = '0;
          track_n = key_idx;
        end
      end
      ST_DELAY: begin
        if (!same_key) begin
          state_n = ST_IDLE;
        end else if (timer == DELAY_LAST) begin
          state_n = ST_REPEAT;
          timer_n = '0;
          rep     = 4'b0001 << track;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      ST_REPEAT: begin
        if (!same_key) begin
          state_n = ST_IDLE;
        end else if (timer == PERIOD_LAST) begin
          timer_n = '0;
          rep     = 4'b0001 << track;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      timer     <= '0;
      track     <= '0;
      dir_pulse <= '0;
      a_pulse   <= 1'b0;
      b_pulse   <= 1'b0;
    end else begin
      state     <= state_n;
      timer     <= timer_n;
      track     <= track_n;
      dir_pulse <= press[3:0] | rep;
      a_pulse   <= press[4];
      b_pulse   <= press[5];
    end
  end

  assign a_held = deb[4];
  assign b_held = deb[5];
  assign mode   = deb[6];

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with short debounce/repeat parameters.
module tb_btn_conditioner;

  logic       clk;
  logic       rst;
  logic [3:0] btn_raw;
  logic       a_raw;
  logic       b_raw;
  logic       mode_raw;
  logic [3:0] dir_pulse;
  logic       a_pulse;
  logic       b_pulse;
  logic       a_held;
  logic       b_held;
  logic       mode;

  int errors;
  int checks;

  typedef struct {
    logic [3:0] btn;
    logic       a;
    logic       b;
    logic       m;
    logic [3:0] e_dir;
    logic       e_ap;
    logic       e_bp;
    logic       e_ah;
    logic       e_bh;
    logic       e_mode;
  } vec_t;

  vec_t vecs[$];

  btn_conditioner #(
    .DEB_CYCLES(4),
    .REP_DELAY (10),
    .REP_PERIOD(3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_raw  (btn_raw),
    .a_raw    (a_raw),
    .b_raw    (b_raw),
    .mode_raw (mode_raw),
    .dir_pulse(dir_pulse),
    .a_pulse  (a_pulse),
    .b_pulse  (b_pulse),
    .a_held   (a_held),
    .b_held   (b_held),
    .mode     (mode)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic applyStimulus(input logic [3:0] btn, input logic a, input logic b, input logic m);
    btn_raw  = btn;
    a_raw    = a;
    b_raw    = b;
    mode_raw = m;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] e_dir, input logic e_ap,
                             input logic e_bp, input logic e_ah, input logic e_bh, input logic e_mode);
    logic [8:0] act;
    logic [8:0] exp;
    act = {dir_pulse, a_pulse, b_pulse, a_held, b_held, mode};
    exp = {e_dir, e_ap, e_bp, e_ah, e_bh, e_mode};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got dir=%b ap=%b bp=%b ah=%b bh=%b mode=%b, want dir=%b ap=%b bp=%b ah=%b bh=%b mode=%b",
               name, act[8:5], act[4], act[3], act[2], act[1], act[0],
               exp[8:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic addVec(input int n, input logic [3:0] btn, input logic a, input logic b, input logic m,
                        input logic [3:0] e_dir, input logic e_ap, input logic e_bp,
                        input logic e_ah, input logic e_bh, input logic e_mode);
    vec_t v;
    v.btn = btn; v.a = a; v.b = b; v.m = m;
    v.e_dir = e_dir; v.e_ap = e_ap; v.e_bp = e_bp;
    v.e_ah = e_ah; v.e_bh = e_bh; v.e_mode = e_mode;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic idleCycles(input int n);
    applyStimulus(4'b1111, 1'b1, 1'b1, 1'b0);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;

    // Key press 1 held 5 cycles, then released.
    addVec(5, 4'b1101, 1, 1, 0, 4'b0000, 0, 0, 0, 0, 0);
    addVec(1, 4'b1111, 1, 1, 0, 4'b0010, 0, 0, 0, 0, 0);
    addVec(8, 4'b1111, 1, 1, 0, 4'b0000, 0, 0, 0, 0, 0);
    // Bouncing a key never reaches the debounce threshold.
    addVec(3, 4'b1111, 0, 1, 0, 4'b0000, 0, 0, 0, 0, 0);
    addVec(1, 4'b1111, 1, 1, 0, 4'b0000, 0, 0, 0, 0, 0);
    addVec(3, 4'b1111, 0, 1, 0, 4'b0000, 0, 0, 0, 0, 0);
    addVec(6, 4'b1111, 1, 1, 0, 4'b0000, 0, 0, 0, 0, 0);
    // Mode switch on then off.
    addVec(5, 4'b1111, 1, 1, 1, 4'b0000, 0, 0, 0, 0, 0);
    addVec(3, 4'b1111, 1, 1, 1, 4'b0000, 0, 0, 0, 0, 1);
    addVec(5, 4'b1111, 1, 1, 0, 4'b0000, 0, 0, 0, 0, 1);
    addVec(2, 4'b1111, 1, 1, 0, 4'b0000, 0, 0, 0, 0, 0);
    // b pressed first, a one cycle later; released in the same order.
    addVec(1, 4'b1111, 1, 0, 0, 4'b0000, 0, 0, 0, 0, 0);
    addVec(4, 4'b1111, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0);
    addVec(1, 4'b1111, 0, 0, 0, 4'b0000, 0, 1, 0, 1, 0);
    addVec(1, 4'b1111, 0, 0, 0, 4'b0000, 1, 0, 1, 1, 0);
    addVec(1, 4'b1111, 0, 0, 0, 4'b0000, 0, 0, 1, 1, 0);
    addVec(1, 4'b1111, 0, 1, 0, 4'b0000, 0, 0, 1, 1, 0);
    addVec(4, 4'b1111, 1, 1, 0, 4'b0000, 0, 0, 1, 1, 0);
    addVec(1, 4'b1111, 1, 1, 0, 4'b0000, 0, 0, 1, 0, 0);
    addVec(1, 4'b1111, 1, 1, 0, 4'b0000, 0, 0, 0, 0, 0);

    applyStimulus(4'b1111, 1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("reset_hold", 4'b0000, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_state", 4'b0000, 0, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].btn, vecs[i].a, vecs[i].b, vecs[i].m);
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec[%0d]", i), vecs[i].e_dir, vecs[i].e_ap, vecs[i].e_bp,
                  vecs[i].e_ah, vecs[i].e_bh, vecs[i].e_mode);
    end

    // Right key held 30 cycles: press, hold delay, then periodic repeats until release lands.
    idleCycles(10);
    applyStimulus(4'b0111, 1'b1, 1'b1, 1'b0);
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("repeat_e%0d", e),
                  (e inside {6, 16, 19, 22, 25, 28, 31, 34}) ? 4'b1000 : 4'b0000, 0, 0, 0, 0, 0);
      if (e == 30) applyStimulus(4'b1111, 1'b1, 1'b1, 1'b0);
    end

    // Left held, down added during the hold delay: repeat cancelled.
    idleCycles(10);
    applyStimulus(4'b1110, 1'b1, 1'b1, 1'b0);
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("multi_e%0d", e),
                  (e == 6) ? 4'b0001 : ((e == 13) ? 4'b0100 : 4'b0000), 0, 0, 0, 0, 0);
      if (e == 7)  applyStimulus(4'b1010, 1'b1, 1'b1, 1'b0);
      if (e == 30) applyStimulus(4'b1111, 1'b1, 1'b1, 1'b0);
    end

    // Up, a and mode held into repeat, then reset pulsed low.
    idleCycles(10);
    applyStimulus(4'b1101, 1'b0, 1'b1, 1'b1);
    for (int e = 1; e <= 19; e++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("prerst_e%0d", e),
                  (e inside {6, 16, 19}) ? 4'b0010 : 4'b0000, (e == 6), 0, (e >= 6), 0, (e >= 6));
    end
    #1 rst = 1'b0;
    #1;
    checkOutput("rst_immediate", 4'b0000, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("postrst_e%0d", e),
                  (e == 6) ? 4'b0010 : 4'b0000, (e == 6), 0, (e >= 6), 0, (e >= 6));
    end
    idleCycles(10);
    checkOutput("final_idle", 4'b0000, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
